// File: rtl/axi_pack.sv
// Shared AXI read-channel types and helpers for the read arbiter slice.
package axi_pack;

    localparam int AXI_ADDR_W = 32;

    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;
    typedef logic [1:0] resp_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        len_t                  len;
        size_t                 size;
        burst_t                burst;
    } ar_chan_t;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_HOLD = 1'b1
    } ar_state_t;

    // (base + off) mod n, valid for base < n and off < n
    function automatic int unsigned wrap_idx(int unsigned base, int unsigned off, int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/axi_rd_order_fifo.sv
// Grant-order FIFO: remembers which requester owns each outstanding read burst.
module axi_rd_order_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rd_ptr];

    // a full FIFO refuses a push even if a pop frees a slot in the same cycle
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read master among NUM_REQ requesters; R bursts are steered back in grant order.
// Define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
//   state   | meaning
//   AR_IDLE | output AR register empty, m_arvalid_o=0
//   AR_HOLD | output AR register holds a request, m_arvalid_o=1
module axi_rd_arbiter
    import axi_pack::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  logic [NUM_REQ-1:0]               s_arvalid_i,
    output logic [NUM_REQ-1:0]               s_arready_o,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   s_araddr_i,
    input  len_t   [NUM_REQ-1:0]             s_arlen_i,
    input  size_t  [NUM_REQ-1:0]             s_arsize_i,
    input  burst_t [NUM_REQ-1:0]             s_arburst_i,

    output logic [NUM_REQ-1:0]               s_rvalid_o,
    input  logic [NUM_REQ-1:0]               s_rready_i,
    output logic [DATA_W-1:0]                s_rdata_o,
    output resp_t                            s_rresp_o,
    output logic                             s_rlast_o,

    output logic                             m_arvalid_o,
    input  logic                             m_arready_i,
    output logic [ADDR_W-1:0]                m_araddr_o,
    output len_t                             m_arlen_o,
    output size_t                            m_arsize_o,
    output burst_t                           m_arburst_o,

    input  logic                             m_rvalid_i,
    output logic                             m_rready_o,
    input  logic [DATA_W-1:0]                m_rdata_i,
    input  resp_t                            m_rresp_i,
    input  logic                             m_rlast_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    ar_state_t          r_state;
    ar_chan_t           r_ar;
    logic [IDX_W-1:0]   r_ptr;

    logic [2*NUM_REQ-1:0] w_rot;
    logic                 w_found;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [IDX_W-1:0]     w_ptr_next;
    logic                 w_ar_free;
    logic                 w_accept;
    ar_chan_t             w_ar_next;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [IDX_W-1:0]     w_head;
    logic                 w_pop;

    // rotate so bit 0 is the requester at the pointer, then take the first set bit
    assign w_rot = {s_arvalid_i, s_arvalid_i} >> r_ptr;

    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'(wrap_idx(32'(r_ptr), k, NUM_REQ));
            end
        end
    end

    assign w_ar_free   = (r_state == AR_IDLE) | m_arready_i;
    assign w_accept    = w_found & w_ar_free & ~w_fifo_full;
    assign s_arready_o = w_accept ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_ptr_next  = (w_grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        w_ar_next       = '0;
        w_ar_next.addr  = AXI_ADDR_W'(s_araddr_i[w_grant_idx]);
        w_ar_next.len   = s_arlen_i[w_grant_idx];
        w_ar_next.size  = s_arsize_i[w_grant_idx];
        w_ar_next.burst = s_arburst_i[w_grant_idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= AR_IDLE;
            r_ar    <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                AR_IDLE: if (w_accept) r_state <= AR_HOLD;
                AR_HOLD: if (m_arready_i && !w_accept) r_state <= AR_IDLE;
            endcase
            if (w_accept) begin
                r_ar  <= w_ar_next;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
                r_ptr <= '0;
`else
                r_ptr <= w_ptr_next;
`endif
            end
        end
    end

    assign m_arvalid_o = (r_state == AR_HOLD);
    assign m_araddr_o  = r_ar.addr[ADDR_W-1:0];
    assign m_arlen_o   = r_ar.len;
    assign m_arsize_o  = r_ar.size;
    assign m_arburst_o = r_ar.burst;

    axi_rd_order_fifo #(
        .DEPTH (OUTSTANDING),
        .W     (IDX_W)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_accept),
        .pop_i   (w_pop),
        .data_i  (w_grant_idx),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .head_o  (w_head)
    );

    assign m_rready_o = ~w_fifo_empty & s_rready_i[w_head];
    assign s_rvalid_o = (~w_fifo_empty & m_rvalid_i) ? (NUM_REQ'(1) << w_head) : '0;
    assign s_rdata_o  = m_rdata_i;
    assign s_rresp_o  = m_rresp_i;
    assign s_rlast_o  = m_rlast_i;
    assign w_pop      = m_rvalid_i & m_rready_o & m_rlast_i;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expectations queued by stimulus, checked by a monitor.
module tb_axi_rd_arbiter;
    import axi_pack::*;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NR-1:0]          s_arvalid;
    logic [NR-1:0]          s_arready;
    logic [NR-1:0][AW-1:0]  s_araddr;
    len_t   [NR-1:0]        s_arlen;
    size_t  [NR-1:0]        s_arsize;
    burst_t [NR-1:0]        s_arburst;
    logic [NR-1:0]          s_rvalid;
    logic [NR-1:0]          s_rready;
    logic [DW-1:0]          s_rdata;
    resp_t                  s_rresp;
    logic                   s_rlast;
    logic                   m_arvalid;
    logic                   m_arready;
    logic [AW-1:0]          m_araddr;
    len_t                   m_arlen;
    size_t                  m_arsize;
    burst_t                 m_arburst;
    logic                   m_rvalid;
    logic                   m_rready;
    logic [DW-1:0]          m_rdata;
    resp_t                  m_rresp;
    logic                   m_rlast;

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .OUTSTANDING(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_arvalid_i(s_arvalid), .s_arready_o(s_arready), .s_araddr_i(s_araddr),
        .s_arlen_i(s_arlen), .s_arsize_i(s_arsize), .s_arburst_i(s_arburst),
        .s_rvalid_o(s_rvalid), .s_rready_i(s_rready), .s_rdata_o(s_rdata),
        .s_rresp_o(s_rresp), .s_rlast_o(s_rlast),
        .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
        .m_arlen_o(m_arlen), .m_arsize_o(m_arsize), .m_arburst_o(m_arburst),
        .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata),
        .m_rresp_i(m_rresp), .m_rlast_i(m_rlast)
    );

    int total = 0;
    int bad   = 0;

    logic [NR-1:0]    q_grant[$];
    logic [39:0]      q_ar[$];
    logic [NR+DW:0]   q_r[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] oh(int port);
        logic [NR-1:0] v;
        v = '0;
        v[port] = 1'b1;
        return v;
    endfunction

    task automatic exp_ar(int port, logic [31:0] a, logic [7:0] l);
        q_grant.push_back(oh(port));
        q_ar.push_back({a, l});
    endtask

    task automatic exp_r(int port, logic [31:0] d, logic l);
        q_r.push_back({oh(port), d, l});
    endtask

    task automatic set_req(int i, logic v, logic [31:0] a, logic [7:0] l);
        s_arvalid[i] = v;
        s_araddr[i]  = a;
        s_arlen[i]   = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // called just after a rising edge; returns just after the handshake edge
    task automatic r_beat(logic [31:0] d, logic l);
        m_rvalid = 1'b1;
        m_rdata  = d;
        m_rlast  = l;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (m_rready) break;
        end
        chk("rready_wait", m_rready, 1);
        step();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (s_arready != '0) begin
            if (q_grant.size() == 0) chk("grant_unexpected", s_arready, 0);
            else                     chk("grant", s_arready, q_grant.pop_front());
        end
        if (m_arvalid && m_arready) begin
            if (q_ar.size() == 0) chk("ar_unexpected", {m_araddr, m_arlen}, 0);
            else                  chk("ar_payload", {m_araddr, m_arlen}, q_ar.pop_front());
        end
        if ((s_rvalid & s_rready) != '0) begin
            if (q_r.size() == 0) chk("r_unexpected", {s_rvalid, s_rdata, s_rlast}, 0);
            else                 chk("r_beat", {s_rvalid, s_rdata, s_rlast}, q_r.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_rready = '1;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_arlen", m_arlen, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_rready", m_rready, 0);

        // single request, 4-beat burst to req0
        step();
        m_arready = 1'b1;
        exp_ar(0, 32'h100, 8'd3);
        set_req(0, 1'b1, 32'h100, 8'd3);
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        @(negedge clk);
        chk("ar_latency", m_arvalid, 1);
        step();
        for (int b = 0; b < 4; b++) begin
            exp_r(0, 32'hA000 + 32'(b), (b == 3));
            r_beat(32'hA000 + 32'(b), (b == 3));
        end
        @(negedge clk);
        chk("empty_rready", m_rready, 0);
        step();

        // arbitration order with both requesters holding valid
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
            exp_ar(0, 32'h200, 8'd0);
`else
            if (i % 2 == 0) exp_ar(0, 32'h200, 8'd0);
            else            exp_ar(1, 32'h300, 8'd0);
`endif
        end
        set_req(0, 1'b1, 32'h200, 8'd0);
        set_req(1, 1'b1, 32'h300, 8'd0);
        repeat (4) step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        set_req(1, 1'b0, 32'h0, 8'd0);
        for (int i = 0; i < 4; i++) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
            exp_r(0, 32'hB0 + 32'(i), 1'b1);
`else
            exp_r(i % 2, 32'hB0 + 32'(i), 1'b1);
`endif
            r_beat(32'hB0 + 32'(i), 1'b1);
        end

        // ordering: req1 single beat then req0 three beats
        exp_ar(1, 32'h400, 8'd0);
        set_req(1, 1'b1, 32'h400, 8'd0);
        step();
        set_req(1, 1'b0, 32'h0, 8'd0);
        exp_ar(0, 32'h500, 8'd2);
        set_req(0, 1'b1, 32'h500, 8'd2);
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        exp_r(1, 32'hC0, 1'b1);
        r_beat(32'hC0, 1'b1);
        for (int b = 1; b < 4; b++) begin
            exp_r(0, 32'hC0 + 32'(b), (b == 3));
            r_beat(32'hC0 + 32'(b), (b == 3));
        end

        // AR backpressure: payload held, no accept, then back-to-back
        m_arready = 1'b0;
        exp_ar(0, 32'h600, 8'd1);
        set_req(0, 1'b1, 32'h600, 8'd1);
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        exp_ar(1, 32'h700, 8'd0);
        set_req(1, 1'b1, 32'h700, 8'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_arready", s_arready, 0);
            chk("bp_arvalid", m_arvalid, 1);
            chk("bp_addr", m_araddr, 32'h600);
            step();
        end
        m_arready = 1'b1;
        step();
        set_req(1, 1'b0, 32'h0, 8'd0);
        @(negedge clk);
        chk("b2b_arvalid", m_arvalid, 1);
        chk("b2b_addr", m_araddr, 32'h700);
        step();
        exp_r(0, 32'hD0, 1'b0);
        r_beat(32'hD0, 1'b0);
        exp_r(0, 32'hD1, 1'b1);
        r_beat(32'hD1, 1'b1);
        exp_r(1, 32'hD2, 1'b1);
        r_beat(32'hD2, 1'b1);

        // full order FIFO: 5th request stalls until a pop frees a slot
        for (int i = 0; i < 5; i++) exp_ar(0, 32'h800, 8'd0);
        set_req(0, 1'b1, 32'h800, 8'd0);
        repeat (4) step();
        @(negedge clk);
        chk("full_stall", s_arready, 0);
        step();
        @(negedge clk);
        chk("full_stall2", s_arready, 0);
        step();
        m_rvalid = 1'b1; m_rdata = 32'hE0; m_rlast = 1'b1;
        exp_r(0, 32'hE0, 1'b1);
        @(negedge clk);
        chk("full_pop_blocks", s_arready, 0);
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clk);
        chk("slot_freed", s_arready, 2'b01);
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        for (int i = 1; i < 5; i++) begin
            exp_r(0, 32'hE0 + 32'(i), 1'b1);
            r_beat(32'hE0 + 32'(i), 1'b1);
        end

        // reset during beat 2 of a 4-beat burst
        exp_ar(0, 32'h900, 8'd3);
        set_req(0, 1'b1, 32'h900, 8'd3);
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        step();
        exp_r(0, 32'hF0, 1'b0);
        r_beat(32'hF0, 1'b0);
        m_rvalid = 1'b1; m_rdata = 32'hF1; m_rlast = 1'b0;
        exp_r(0, 32'hF1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_rdata = 32'hF2;
        @(negedge clk);
        chk("mid_rst_rvalid", s_rvalid, 0);
        chk("mid_rst_rready", m_rready, 0);
        chk("mid_rst_arvalid", m_arvalid, 0);
        chk("mid_rst_araddr", m_araddr, 0);
        chk("mid_rst_arready", s_arready, 0);
        step();
        m_rvalid = 1'b0;
        repeat (2) step();

        chk("queues_drained", q_grant.size() + q_ar.size() + q_r.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
